complex_to_pixel: RTL and testbench

COMPLEX_TO_PIXEL -- requirements
Module: complex_to_pixel

---
 rtl/complex_to_pixel.sv | 179 +++++++++++++++++
 tb/tb_complex_to_pixel.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/complex_to_pixel.sv
// Maps a Q4.28 complex point to a screen pixel using a 10-step restoring divider per axis.
// Optional macro COMPLEX_TO_PIXEL_CLAMP_EN: clamp out-of-range axes to the screen edge instead of 0x7FF.

module c2p_axis #(
  parameter int WL    = 32,
  parameter int SCALE = 640
) (
  input  logic                 clk,
  input  logic                 load,
  input  logic                 step,
  input  logic                 degen,
  input  logic signed [WL:0]   d,
  input  logic signed [WL-1:0] ext,
  output logic [10:0]          res,
  output logic                 ok
);
  localparam int NW = WL + 11;
  localparam logic signed [WL:0] ONE = 1;

  logic signed [WL:0] ext_w, dsel;
  logic               deg, ok_c, ge;
  logic [NW-1:0]      num_c, rem, dsh;
  logic [9:0]         q, q_nxt;

  always_comb begin
    ext_w = {ext[WL-1], ext};
    ok_c  = !degen && (d >= 0) && (d < ext_w);
`ifdef COMPLEX_TO_PIXEL_CLAMP_EN
    if (degen || d < 0)  dsel = '0;
    else if (d >= ext_w) dsel = ext_w - ONE;
    else                 dsel = d;
`else
    dsel = ok_c ? d : '0;
`endif
    // dsel < ext, so the quotient always fits in 10 bits
    num_c = NW'(dsel) * NW'(SCALE);
    ge    = (rem >= dsh);
    q_nxt = (q << 1) | 10'(ge);
  end

  always_ff @(posedge clk) begin
    if (load) begin
      rem <= num_c;
      dsh <= NW'($unsigned(ext)) << 9;
      q   <= '0;
      ok  <= ok_c;
      deg <= degen;
    end else if (step) begin
      if (ge) rem <= rem - dsh;
      dsh <= dsh >> 1;
      q   <= q_nxt;
    end
  end

  // q_nxt so the owner can capture the result on the final divide edge
`ifdef COMPLEX_TO_PIXEL_CLAMP_EN
  assign res = deg ? 11'h000 : {1'b0, q_nxt};
`else
  assign res = (ok && !deg) ? {1'b0, q_nxt} : 11'h7FF;
`endif
endmodule

module complex_to_pixel #(
  parameter int WORD_LENGTH   = 32,
  parameter int FRAC          = 28,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   ZOOM_RECIPROCAL,
  input  logic signed [WORD_LENGTH-1:0] real_center,
  input  logic signed [WORD_LENGTH-1:0] imag_center,
  input  logic signed [WORD_LENGTH-1:0] real_part,
  input  logic signed [WORD_LENGTH-1:0] im_part,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [10:0]                   x,
  output logic [10:0]                   y,
  output logic                          in_bounds,
  output logic                          out_valid,
  input  logic                          out_ready
);
  localparam int WL = WORD_LENGTH;
  // ZOOM_RECIPROCAL is always Q4.28; realign it to the coordinate format
  localparam int ZL = (FRAC >= 28) ? FRAC - 28 : 0;
  localparam int ZR = (FRAC >= 28) ? 0 : 28 - FRAC;

  typedef enum logic [1:0] {IDLE, PREP, DIV, HOLD} state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic [31:0]        zoom_q;
  logic signed [WL-1:0] rc_q, ic_q, re_q, im_q;
  logic signed [WL-1:0] z_w, rw, ih, real_min, imag_max;
  logic signed [WL:0]   dx, dy;
  logic               degen;
  logic [1:0][WL:0]   d;
  logic [1:0][WL-1:0] ext;
  logic [1:0][10:0]   res;
  logic [1:0]         ok;

  assign in_ready = (state == IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      zoom_q <= ZOOM_RECIPROCAL;
      rc_q   <= real_center;
      ic_q   <= imag_center;
      re_q   <= real_part;
      im_q   <= im_part;
    end
  end

  always_comb begin
    z_w      = signed'((WL'(zoom_q) << ZL) >> ZR);
    rw       = (z_w <<< 1) + z_w;
    ih       = z_w <<< 1;
    real_min = rc_q - (rw >>> 1);
    imag_max = ic_q + (ih >>> 1);
    dx       = {re_q[WL-1], re_q} - {real_min[WL-1], real_min};
    dy       = {imag_max[WL-1], imag_max} - {im_q[WL-1], im_q};
    degen    = (rw <= 0) || (ih <= 0);
    d[0]     = dx;
    d[1]     = dy;
    ext[0]   = rw;
    ext[1]   = ih;
  end

  for (genvar a = 0; a < 2; a++) begin : g_axis
    c2p_axis #(
      .WL    (WL),
      .SCALE (a == 0 ? SCREEN_WIDTH : SCREEN_HEIGHT)
    ) u_axis (
      .clk   (clk),
      .load  (state == PREP),
      .step  (state == DIV),
      .degen (degen),
      .d     (d[a]),
      .ext   (ext[a]),
      .res   (res[a]),
      .ok    (ok[a])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      x         <= '0;
      y         <= '0;
      in_bounds <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) state <= PREP;
        PREP: begin
          cnt   <= '0;
          state <= DIV;
        end
        DIV: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd9) begin
            state     <= HOLD;
            x         <= res[0];
            y         <= res[1];
            in_bounds <= ok[0] & ok[1];
            out_valid <= 1'b1;
          end
        end
        HOLD: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_complex_to_pixel.sv
// Directed bench for complex_to_pixel; expectations adapt to COMPLEX_TO_PIXEL_CLAMP_EN.

module tb_complex_to_pixel;
`ifdef COMPLEX_TO_PIXEL_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif
  localparam logic [31:0] Z1  = 32'h1000_0000;
  localparam logic [31:0] RC  = 32'hF800_0000;  // -0.5
  localparam logic [31:0] IC  = 32'h0000_0000;
  localparam logic [10:0] XO  = CLAMP ? 11'd639 : 11'h7FF;
  localparam logic [10:0] YO  = CLAMP ? 11'd479 : 11'h7FF;
  localparam logic [10:0] DG  = CLAMP ? 11'd0   : 11'h7FF;

  logic               clk = 1'b0, reset = 1'b1;
  logic [31:0]        zoom = '0;
  logic signed [31:0] rc = '0, ic = '0, re = '0, im = '0;
  logic               in_valid = 1'b0, out_ready = 1'b0;
  logic               in_ready, in_bounds, out_valid;
  logic [10:0]        x, y;
  int                 errors = 0, checks = 0, lat;

  complex_to_pixel dut (
    .clk             (clk),
    .reset           (reset),
    .ZOOM_RECIPROCAL (zoom),
    .real_center     (rc),
    .imag_center     (ic),
    .real_part       (re),
    .im_part         (im),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .x               (x),
    .y               (y),
    .in_bounds       (in_bounds),
    .out_valid       (out_valid),
    .out_ready       (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    zoom = $urandom; rc = $urandom; ic = $urandom; re = $urandom; im = $urandom;
  endtask

  // Returns #1 after the accepting edge, with the inputs scrambled.
  task automatic send(input logic [31:0] z, input logic [31:0] c_r, input logic [31:0] c_i,
                      input logic [31:0] p_r, input logic [31:0] p_i);
    int n;
    @(negedge clk);
    zoom = z; rc = c_r; ic = c_i; re = p_r; im = p_i; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
  endtask

  // Edges after the accept edge until out_valid is seen (11 -> HOLD is the 12th cycle after accept).
  task automatic wait_valid(output int l);
    l = 0;
    while (!out_valid && l < 40) begin @(posedge clk); #1; l++; end
  endtask

  task automatic pop(input string tag);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({tag, "_ovdrop"}, out_valid, 0);
    chk({tag, "_rdy"}, in_ready, 1);
  endtask

  task automatic run(input string tag, input logic [31:0] z, input logic [31:0] p_r,
                     input logic [31:0] p_i, input logic [10:0] ex, input logic [10:0] ey,
                     input logic eb);
    send(z, RC, IC, p_r, p_i);
    wait_valid(lat);
    chk({tag, "_lat"}, lat, 11);
    chk({tag, "_x"}, x, ex);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_inb"}, in_bounds, eb);
    pop(tag);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_inb", in_bounds, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_rdy", in_ready, 0);
    @(negedge clk); reset = 1'b0;
    #1 chk("idle_rdy", in_ready, 1);

    run("tl",    Z1, 32'hE000_0000, 32'h1000_0000, 11'd0,   11'd0,   1'b1);
    run("ctr",   Z1, 32'hF800_0000, 32'h0000_0000, 11'd320, 11'd240, 1'b1);
    run("gen",   Z1, 32'h0000_0000, 32'h0800_0000, 11'd426, 11'd120, 1'b1);
    run("redge", Z1, 32'h0FFF_FFFF, 32'h0000_0000, 11'd639, 11'd240, 1'b1);
    run("rout",  Z1, 32'h1000_0000, 32'h0000_0000, XO,      11'd240, 1'b0);
    run("bout",  Z1, 32'hF800_0000, 32'hF000_0000, 11'd320, YO,      1'b0);
    run("lout",  Z1, 32'hDFFF_FFFF, 32'h0000_0000, CLAMP ? 11'd0 : 11'h7FF, 11'd240, 1'b0);
    run("deg",   32'h0, 32'h1234_5678, 32'h0000_0000, DG,   DG,      1'b0);

    // backpressure, then a request held across the HOLD exit edge
    send(Z1, RC, IC, 32'hF800_0000, 32'h0000_0000);
    wait_valid(lat);
    chk("bp_lat", lat, 11);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_ov", out_valid, 1);
      chk("bp_x", x, 320);
      chk("bp_y", y, 240);
      chk("bp_inb", in_bounds, 1);
      chk("bp_rdy", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    zoom = Z1; rc = RC; ic = IC; re = 32'hE000_0000; im = 32'h1000_0000;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("exit_ov", out_valid, 0);
    chk("exit_noacc", in_ready, 1);
    @(posedge clk); #1; in_valid = 1'b0; scramble();
    chk("next_acc", in_ready, 0);
    wait_valid(lat);
    chk("next_lat", lat, 11);
    chk("next_x", x, 0);
    chk("next_y", y, 0);
    chk("next_inb", in_bounds, 1);
    pop("next");

    // reset during DIV cycle 5
    send(Z1, RC, IC, 32'h0000_0000, 32'h0800_0000);
    repeat (5) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("mrst_ov", out_valid, 0);
    chk("mrst_x", x, 0);
    chk("mrst_y", y, 0);
    chk("mrst_inb", in_bounds, 0);
    @(negedge clk); reset = 1'b0;
    #1 chk("mrst_rdy", in_ready, 1);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      chk("mrst_noov", out_valid, 0);
    end
    run("post", Z1, 32'hF800_0000, 32'h0000_0000, 11'd320, 11'd240, 1'b1);

    // reset wins over a simultaneous request
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1;
    zoom = Z1; rc = RC; ic = IC; re = 32'h0; im = 32'h0;
    @(posedge clk); #1;
    chk("prio_rdy", in_ready, 0);
    @(negedge clk); reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      chk("prio_noov", out_valid, 0);
    end
    chk("prio_idle", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
